jk_ff_checker: RTL
==================

// Module: jk_ff_checker
// PURPOSE
//  Stimulus generator and self-checker for the jk_ff flip-flop: drives j/k into an
//  external jk_ff, samples its q, and compares it against an internal JK model.
//  On-chip equivalent of the j/k testbench. Sits beside the jk_ff under test in the
//  tt03 wrapper; start/done/err_cnt are exposed to the top-level pins.
// PARAMETERS
//  N_VEC   16     vectors issued per run after the sync vector (1..1023)
//  SEED    8'hA5  LFSR seed loaded at each start (must be non-zero)
// PORTS
//  clk      in   1      single clock; jk_ff under test uses the same clk
//  rst_n    in   1      asynchronous, active-low reset
//  start    in   1      run request; sampled only in IDLE
//  mode     in   2      00 toggle(j=k=1), 01 hold(j=k=0), 10 LFSR random, 11 walk
//  q        in   1      q output of the jk_ff under test
//  j        out  1      registered J drive
//  k        out  1      registered K drive
//  busy     out  1      high from start acceptance until done
//  done     out  1      one-cycle pulse at end of run
//  pass     out  1      err_cnt==0 at done; held until next accepted start
//  err_cnt  out  8      mismatch count, saturates at 255
//  vec_cnt  out  $clog2(N_VEC+1)  vectors issued in the current run
// BEHAVIOUR
//  Reset: state=IDLE, j=0, k=0 (DUT holds), busy=0, done=0, pass=0, err_cnt=0,
//   vec_cnt=0, LFSR=SEED, model q=0, compare pipeline invalid.
//  States:
//   IDLE  -> SYNC on start: mode latched; err_cnt, vec_cnt cleared; LFSR=SEED; busy=1.
//   SYNC  one cycle: j=0,k=1 (forces DUT q=0); model q=0; -> RUN.
//   RUN   N_VEC cycles, one vector per edge, vec_cnt+1 per vector:
//         mode00 j=k=1; mode01 j=k=0; mode10 {j,k}=LFSR[1:0], LFSR steps every vector;
//         mode11 {j,k} cycles 00,01,10,11 from vec_cnt=0. -> DRAIN after vector N_VEC.
//   DRAIN 2 cycles, j=k=0; last compares retire. -> DONE.
//   DONE  one cycle: done=1, busy=0, pass updated; -> IDLE.
//  Model: on each issued vector, q_m <= JK(q_m,j,k): 00 hold, 01 0, 10 1, 11 ~q_m.
//  Latency: vector registered at edge t; DUT captures at edge t+1; checker samples q
//   at edge t+2. Expected value travels in a 2-stage pipeline with a valid bit.
//   The sync vector is also checked (expect 0).
//  Compare: valid && q!=expected -> err_cnt+1 unless already 255 (saturate, no wrap).
//  Timing: start accepted at edge s -> done high in the cycle after edge s+N_VEC+3.
//  start while busy is ignored; the mode change mid-run is ignored (latched copy used).
//  start held high continuously: a new run begins at the edge after DONE, one IDLE cycle.
//  rst_n low mid-run: async return to reset values at once; no done pulse; partial
//   counts are lost.
//  X on q: counted as a mismatch. Synthesis treats q as 0/1.
// STRUCTURE
//  Package jk_chk_pkg: mode encodings (MODE_TOGGLE, MODE_HOLD, MODE_RAND, MODE_WALK),
//   state enum {IDLE,SYNC,RUN,DRAIN,DONE}, ERR_MAX=8'd255.
//  Sub-module lfsr8: Fibonacci, taps x^8+x^6+x^5+x^4+1; ports clk, rst_n, load,
//   seed, step, out[7:0].
//  Top level holds the FSM, JK model, 2-stage compare pipeline and counters.
// TESTING (bench instantiates jk_ff_checker + jk_ff, or a faulty DUT model)
//  1 Good jk_ff, mode00, N_VEC=16: q=0 after sync, then 1,0,1,... -> err_cnt=0, pass=1,
//    done 19 cycles after start edge, vec_cnt=16.
//  2 q tied to 0, mode00, N_VEC=16: expected 1 on odd vectors -> err_cnt=8, pass=0.
//  3 Good jk_ff, mode11: j/k 00,01,10,11,... q 0,0,1,0 repeating -> err_cnt=0;
//    q tied 1 -> sync and every 0-expectation fail (err_cnt=13 for N_VEC=16).
//  4 mode10, SEED=8'hA5: j/k sequence matches lfsr8 reference; good DUT -> pass=1;
//    second run gives the identical j/k sequence (reseed).
//  5 rst_n pulsed low at RUN vector 5: j=k=0, busy=0, err_cnt=0 same cycle; no done;
//    start pulse mid-run is ignored (single done per run).
//  6 Saturation: N_VEC=600, q tied 0, mode00 -> err_cnt stays 255, pass=0.

Source files
------------

// File: rtl/jk_chk_pkg.sv
// Shared encodings for the jk_ff on-chip checker.
package jk_chk_pkg;

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_HOLD   = 2'b01;
  localparam logic [1:0] MODE_RAND   = 2'b10;
  localparam logic [1:0] MODE_WALK   = 2'b11;

  localparam logic [7:0] ERR_MAX = 8'd255;

  typedef enum logic [2:0] {IDLE, SYNC, RUN, DRAIN, DONE} state_e;

  // Next value of an ideal JK flip-flop.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    unique case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_ff_checker_if.sv
// Signal bundle between the checker and its environment (pins + jk_ff under test).
interface jk_ff_checker_if #(
  parameter int unsigned N_VEC = 16
);
  localparam int unsigned VCW = $clog2(N_VEC + 1);

  logic           start;
  logic [1:0]     mode;
  logic           q;
  logic           j;
  logic           k;
  logic           busy;
  logic           done;
  logic           pass;
  logic [7:0]     err_cnt;
  logic [VCW-1:0] vec_cnt;

  // Checker side.
  modport master (
    input  start, mode, q,
    output j, k, busy, done, pass, err_cnt, vec_cnt
  );

  // Environment side.
  modport slave (
    output start, mode, q,
    input  j, k, busy, done, pass, err_cnt, vec_cnt
  );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, loadable seed.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] out
);

  logic [7:0] state_q;
  logic       fb;

  assign fb  = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];
  assign out = state_q;

  // Load has priority over step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= seed;
    end else if (step) begin
      state_q <= {state_q[6:0], fb};
    end
  end

endmodule

// File: rtl/jk_ff_checker.sv
// Drives j/k into an external jk_ff, models it internally and counts mismatches on q.
module jk_ff_checker
  import jk_chk_pkg::*;
#(
  parameter int unsigned N_VEC = 16,
  parameter logic [7:0]  SEED  = 8'hA5
) (
  input logic             clk,
  input logic             rst_n,
  jk_ff_checker_if.master bus
);

  localparam int unsigned VCW = $clog2(N_VEC + 1);
  localparam logic [VCW-1:0] VEC_LAST = VCW'(N_VEC);

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic           j_q, j_d, k_q, k_d;
  logic           qm_q, qm_d;
  logic           v1_q, v1_d, v2_q;
  logic           e1_q, e2_q;
  logic [7:0]     err_q, err_d;
  logic [VCW-1:0] vcnt_q, vcnt_d;
  logic           pass_q, pass_d;
  logic           drain_q, drain_d;

  logic           accept;
  logic           issue;
  logic [1:0]     vec;
  logic [7:0]     lfsr_out;
  logic           mismatch;

  assign accept = (state_q == IDLE) && bus.start;
  // Sync cycle emits vector 0; RUN emits the rest until the count reaches N_VEC.
  assign issue  = (state_q == SYNC) || ((state_q == RUN) && (vcnt_q != VEC_LAST));
  // X on q must count as a failure, hence the case inequality.
  assign mismatch = v2_q && (bus.q !== e2_q);

  lfsr8 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .seed  (SEED),
    .step  (issue && (mode_q == MODE_RAND)),
    .out   (lfsr_out)
  );

  // Vector selection from the latched mode.
  always_comb begin
    vec = 2'b00;
    unique case (mode_q)
      MODE_TOGGLE: vec = 2'b11;
      MODE_HOLD:   vec = 2'b00;
      MODE_RAND:   vec = lfsr_out[1:0];
      default:     vec = 2'(vcnt_q);
    endcase
  end

  // Next-state, drive, model and counter logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    qm_d    = qm_q;
    v1_d    = 1'b0;
    err_d   = err_q;
    vcnt_d  = vcnt_q;
    pass_d  = pass_q;
    drain_d = 1'b0;

    if (mismatch && (err_q != ERR_MAX)) begin
      err_d = err_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SYNC;
          mode_d  = bus.mode;
          err_d   = 8'd0;
          vcnt_d  = '0;
          pass_d  = 1'b0;
          // Sync vector forces the DUT to 0.
          k_d     = 1'b1;
          qm_d    = 1'b0;
          v1_d    = 1'b1;
        end
      end
      SYNC:  state_d = RUN;
      RUN:   if (vcnt_q == VEC_LAST) state_d = DRAIN;
      DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) begin
          state_d = DONE;
          pass_d  = (err_q == 8'd0);
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      j_d    = vec[1];
      k_d    = vec[0];
      qm_d   = jk_next(qm_q, vec[1], vec[0]);
      v1_d   = 1'b1;
      vcnt_d = vcnt_q + 1'b1;
    end
  end

  // State, drive and compare pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_TOGGLE;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      qm_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      e1_q    <= 1'b0;
      e2_q    <= 1'b0;
      err_q   <= 8'd0;
      vcnt_q  <= '0;
      pass_q  <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      j_q     <= j_d;
      k_q     <= k_d;
      qm_q    <= qm_d;
      // Expected q after the DUT captures this vector, checked two edges later.
      v1_q    <= v1_d;
      e1_q    <= qm_d;
      v2_q    <= v1_q;
      e2_q    <= e1_q;
      err_q   <= err_d;
      vcnt_q  <= vcnt_d;
      pass_q  <= pass_d;
      drain_q <= drain_d;
    end
  end

  assign bus.j       = j_q;
  assign bus.k       = k_q;
  assign bus.busy    = (state_q == SYNC) || (state_q == RUN) || (state_q == DRAIN);
  assign bus.done    = (state_q == DONE);
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;
  assign bus.vec_cnt = vcnt_q;

endmodule
